// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and size-derived byte/offset masks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    // funct3[1:0] encodes log2 of the access size in bytes.
    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00ff;
            2'd1:    m = 64'h0000_0000_0000_ffff;
            2'd2:    m = 64'h0000_0000_ffff_ffff;
            default: m = 64'hffff_ffff_ffff_ffff;
        endcase
        return m;
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] off_low_mask(input logic [1:0] sz);
        logic [2:0] m;
        case (sz)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering: extracts and extends a load field from a
// doubleword, and merges store data into the old doubleword for RMW.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  off,
    input  logic [63:0] old_dw,
    input  logic [63:0] st_data,
    output logic [63:0] ld_val,
    output logic [63:0] st_merged
);

    logic [5:0]  shamt;
    logic [63:0] mask;
    logic [63:0] field;

    always_comb begin
        shamt     = {off, 3'b000};
        mask      = size_mask(funct3[1:0]);
        field     = (old_dw >> shamt) & mask;
        st_merged = (old_dw & ~(mask << shamt)) | ((st_data & mask) << shamt);
        case (funct3)
            F3_B:                      ld_val = {{56{field[7]}}, field[7:0]};
            F3_H:                      ld_val = {{48{field[15]}}, field[15:0]};
            F3_W:                      ld_val = {{32{field[31]}}, field[31:0]};
            F3_D, F3_BU, F3_HU, F3_WU: ld_val = field;
            default:                   ld_val = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit over a doubleword memory without byte enables.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_misaligned,
    output logic        busy,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_rdata
);

    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'd8;

    lsu_state_e  state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [2:0]  off_q, off_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_mis_q, resp_mis_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;

    logic [2:0]  low_mask;
    logic [2:0]  req_off;
    logic        req_illegal;
    logic        req_oor;
    logic        req_mis;
    logic [63:0] ld_val;
    logic [63:0] st_merged;

    always_comb begin
        low_mask    = off_low_mask(req_funct3[1:0]);
        req_off     = req_addr[2:0] & ~low_mask;
        req_illegal = req_write ? (req_funct3 > F3_D) : (req_funct3 > F3_WU);
        req_oor     = (req_addr >= MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
        req_mis     = |(req_addr[2:0] & low_mask);
`else
        req_mis     = 1'b0;
`endif
    end

    // Old doubleword always comes straight from memory during LOAD / RMW_RD.
    lsu_lane_align u_lane_align (
        .funct3    (funct3_q),
        .off       (off_q),
        .old_dw    (mem_rdata),
        .st_data   (wdata_q),
        .ld_val    (ld_val),
        .st_merged (st_merged)
    );

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_mis_d   = 1'b0;
        resp_rdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    off_d      = req_off;
                    wdata_d    = req_wdata;
                    mem_addr_d = {3'b000, req_addr[63:3]};
                    if (req_illegal || req_oor) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_mis) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                    end else if (!req_write) begin
                        state_d    = ST_LOAD;
                        mem_read_d = 1'b1;
                    end else if (req_funct3 == F3_D) begin
                        state_d     = ST_WRITE;
                        mem_write_d = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = ST_RMW_RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_val;
            end
            ST_RMW_RD: begin
                state_d     = ST_WRITE;
                mem_write_d = 1'b1;
                mem_wdata_d = st_merged;
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_mis_q   <= resp_mis_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Request capture registers only matter while busy, so they skip reset.
    always_ff @(posedge clk) begin
        funct3_q <= funct3_d;
        off_q    <= off_d;
        wdata_q  <= wdata_d;
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_rdata      = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of requests with a response scoreboard,
// plus hand-written reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        resp_misaligned;
    logic        busy;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(1024)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .resp_misaligned (resp_misaligned),
        .busy            (busy),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_rdata       (mem_rdata)
    );

    // Memory model with a preload port.
    logic [63:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [63:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_write && (mem_addr < 64'd1024)) mem[mem_addr[9:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_addr < 64'd1024) ? mem[mem_addr[9:0]] : 64'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        mis;
        int          acc;
        int          lat;
        string       name;
    } sb_t;
    sb_t sb[$];

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          resp_cnt = 0;
    logic [63:0] last_wa = '0;
    logic [63:0] last_wd = '0;

    always @(negedge clk) begin : monitor
        sb_t e;
        if (mem_write) begin
            wr_cnt++;
            last_wa = mem_addr;
            last_wd = mem_wdata;
        end
        if (mem_read) rd_cnt++;
        if (resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                chk({e.name, "_err"}, 64'(resp_err), 64'(e.err));
                chk({e.name, "_mis"}, 64'(resp_misaligned), 64'(e.mis));
                chk({e.name, "_lat"}, 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
    end

    typedef struct {
        string       name;
        logic        w;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] rdata;
        logic        err;
        logic        mis;
        int          lat;
        int          rd;
        int          wr;
        logic [63:0] wa;
        logic [63:0] wdx;
    } vec_t;

    function automatic vec_t mk(input string name, input logic w, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wd,
                                input logic [63:0] rdata, input logic err, input logic mis,
                                input int lat, input int rd, input int wr,
                                input logic [63:0] wa, input logic [63:0] wdx);
        vec_t v;
        v.name = name; v.w = w; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.rdata = rdata; v.err = err; v.mis = mis; v.lat = lat;
        v.rd = rd; v.wr = wr; v.wa = wa; v.wdx = wdx;
        return v;
    endfunction

    // Called at negedge+1; returns at negedge+1 once the response has been seen.
    task automatic issue(input vec_t v);
        int  n;
        int  wr0;
        int  rd0;
        sb_t e;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            chk({v.name, "_ready_timeout"}, 64'(req_ready), 64'd1);
        end else begin
            wr0 = wr_cnt;
            rd0 = rd_cnt;
            req_valid  = 1'b1;
            req_write  = v.w;
            req_funct3 = v.f3;
            req_addr   = v.addr;
            req_wdata  = v.wd;
            e.rdata = v.rdata; e.err = v.err; e.mis = v.mis;
            e.acc = cyc + 1; e.lat = v.lat; e.name = v.name;
            sb.push_back(e);
            @(posedge clk); #1;
            req_valid = 1'b0;
            n = 0;
            while (sb.size() != 0 && n < 20) begin
                @(negedge clk); #1; n++;
            end
            if (sb.size() != 0) begin
                chk({v.name, "_resp_timeout"}, 64'(sb.size()), 64'd0);
                sb.delete();
            end
            chk({v.name, "_wr_cycles"}, 64'(wr_cnt - wr0), 64'(v.wr));
            chk({v.name, "_rd_cycles"}, 64'(rd_cnt - rd0), 64'(v.rd));
            if (v.wr != 0) begin
                chk({v.name, "_mem_addr"}, last_wa, v.wa);
                chk({v.name, "_mem_wdata"}, last_wd, v.wdx);
            end
        end
    endtask

    vec_t vecs[$];

    initial begin : main
        int wr0;
        int r0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        vecs.push_back(mk("lb_neg",   0, 3'd0, 64'h17, 0, 64'hFFFF_FFFF_FFFF_FF88, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("lbu",      0, 3'd4, 64'h17, 0, 64'h0000_0000_0000_0088, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("lb_pos",   0, 3'd0, 64'h10, 0, 64'h0000_0000_0000_0011, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("lh",       0, 3'd1, 64'h16, 0, 64'hFFFF_FFFF_FFFF_8877, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("lhu",      0, 3'd5, 64'h16, 0, 64'h0000_0000_0000_8877, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("lw",       0, 3'd2, 64'h14, 0, 64'hFFFF_FFFF_8877_6655, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("lwu",      0, 3'd6, 64'h14, 0, 64'h0000_0000_8877_6655, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("ld",       0, 3'd3, 64'h10, 0, 64'h8877_6655_4433_2211, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("sh",       1, 3'd1, 64'h0A, 64'h1234_0000_0000_BEEF, 0, 0, 0, 3, 1, 1, 64'd1, 64'h0000_0000_BEEF_0000));
        vecs.push_back(mk("ld_sh",    0, 3'd3, 64'h08, 0, 64'h0000_0000_BEEF_0000, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("sd",       1, 3'd3, 64'h20, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 2, 0, 1, 64'd4, 64'h0123_4567_89AB_CDEF));
        vecs.push_back(mk("ld_sd",    0, 3'd3, 64'h20, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("sb",       1, 3'd0, 64'h23, 64'h0000_0000_0000_00AA, 0, 0, 0, 3, 1, 1, 64'd4, 64'h0123_4567_AAAB_CDEF));
        vecs.push_back(mk("sw",       1, 3'd2, 64'h24, 64'hFFFF_FFFF_DEAD_BEEF, 0, 0, 0, 3, 1, 1, 64'd4, 64'hDEAD_BEEF_AAAB_CDEF));
        vecs.push_back(mk("ld_sbsw",  0, 3'd3, 64'h20, 0, 64'hDEAD_BEEF_AAAB_CDEF, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("ld_f3ill", 0, 3'd7, 64'h00, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("ld_oor",   0, 3'd3, 64'h2000, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("ld_top",   0, 3'd3, 64'h1FF8, 0, 64'h5A5A_5A5A_5A5A_5A5A, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("st_f3ill", 1, 3'd4, 64'h10, 64'h55, 0, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("sd_oor",   1, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h55, 0, 1, 0, 1, 0, 0, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_mis",   0, 3'd2, 64'h06, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("sh_mis",   1, 3'd1, 64'h09, 64'h7777, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("ld_shmis", 0, 3'd3, 64'h08, 0, 64'h0000_0000_BEEF_0000, 0, 0, 2, 1, 0, 0, 0));
`else
        vecs.push_back(mk("lw_mis",   0, 3'd2, 64'h06, 0, 64'hFFFF_FFFF_CAFE_BABE, 0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk("sh_mis",   1, 3'd1, 64'h09, 64'h7777, 0, 0, 0, 3, 1, 1, 64'd1, 64'h0000_0000_BEEF_7777));
        vecs.push_back(mk("ld_shmis", 0, 3'd3, 64'h08, 0, 64'h0000_0000_BEEF_7777, 0, 0, 2, 1, 0, 0, 0));
`endif

        // Preload memory while reset is held.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pl_en = 1'b1;
            case (i)
                0: begin pl_addr = 10'd0;    pl_data = 64'hCAFE_BABE_1234_5678; end
                1: begin pl_addr = 10'd1;    pl_data = 64'h0; end
                2: begin pl_addr = 10'd2;    pl_data = 64'h8877_6655_4433_2211; end
                3: begin pl_addr = 10'd4;    pl_data = 64'h0; end
                default: begin pl_addr = 10'd1023; pl_data = 64'h5A5A_5A5A_5A5A_5A5A; end
            endcase
        end
        @(negedge clk);
        pl_en = 1'b0;

        chk("rst_req_ready",  64'(req_ready), 64'd1);
        chk("rst_busy",       64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err",   64'(resp_err), 64'd0);
        chk("rst_resp_mis",   64'(resp_misaligned), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mem_read",   64'(mem_read), 64'd0);
        chk("rst_mem_write",  64'(mem_write), 64'd0);
        chk("rst_mem_addr",   mem_addr, 64'd0);
        chk("rst_mem_wdata",  mem_wdata, 64'd0);

        rst = 1'b0;
        @(negedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);

        // Reset during RMW_RD of SW 0x04: memory must not be written.
        @(negedge clk); #1;
        wr0 = wr_cnt; r0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 64'h04; req_wdata = 64'h1111_2222;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_busy", 64'(busy), 64'd1);
        chk("rmw_mem_read", 64'(mem_read), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rmwrst_req_ready", 64'(req_ready), 64'd1);
        chk("rmwrst_mem_read", 64'(mem_read), 64'd0);
        chk("rmwrst_mem_write", 64'(mem_write), 64'd0);
        repeat (5) @(negedge clk);
        #1;
        chk("rmwrst_no_write", 64'(wr_cnt - wr0), 64'd0);
        chk("rmwrst_no_resp", 64'(resp_cnt - r0), 64'd0);
        issue(mk("ld_after_rmwrst", 0, 3'd3, 64'h00, 0, 64'hCAFE_BABE_1234_5678, 0, 0, 2, 1, 0, 0, 0));

        // Reset coinciding with a request: the request is dropped.
        wr0 = wr_cnt; r0 = resp_cnt;
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd3;
        req_addr = 64'h08; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rstreq_busy", 64'(busy), 64'd0);
        chk("rstreq_req_ready", 64'(req_ready), 64'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("rstreq_no_write", 64'(wr_cnt - wr0), 64'd0);
        chk("rstreq_no_resp", 64'(resp_cnt - r0), 64'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
